pcie_flow_ctrl: RTL
===================

// Module: pcie_flow_ctrl
// PURPOSE
//  Flow-control/sequencing master for the PCIE transaction datapath: main FIFO (MF) -> VC0/VC1 FIFOs -> D0/D1 FIFOs.
//  Runs the link state machine (RESET/INIT/IDLE/ACTIVE/ERROR) and latches almost-full thresholds (umbrales) in INIT.
//  Issues pop strobes for MF and VC0/VC1, arbitrates the shared VC->D demux (VC0 priority, starvation guard), and raises Pausa_MF.
//  The datapath FIFOs and muxes stay external; this block only drives their control lines.
// PARAMETERS
//  MF_CW      3   width of MF occupancy count (depth 4)
//  VC_CW      5   width of VC0/VC1 occupancy counts (depth 16)
//  D_CW       3   width of D0/D1 occupancy counts (depth 4)
//  STARVE_MAX 4   consecutive VC0 grants with VC1 eligible before VC1 is forced one grant (1..15)
//  UMF_RST    3 | UVC_RST 12 | UD_RST 3   threshold reset values
// PORTS
//  clk            in   1      single clock, all logic on posedge
//  reset          in   1      synchronous, active-high
//  init           in   1      request (re)initialisation / threshold load
//  umbral_mf      in   2      MF almost-full threshold, sampled in INIT
//  umbral_vc0     in   4      VC0 threshold;  umbral_vc1 in 4  VC1 threshold
//  umbral_d0      in   2      D0 threshold;   umbral_d1  in 2  D1 threshold
//  mf_count       in   MF_CW  MF occupancy;   vc0_count/vc1_count in VC_CW; d0_count/d1_count in D_CW
//  mf_head_vc     in   1      bit5 of MF head word: target VC
//  vc0_head_dest  in   1      bit4 of VC0 head word: target D;  vc1_head_dest in 1  same for VC1
//  fifo_err       in   5      per-FIFO overflow/underflow flags {d1,d0,vc1,vc0,mf}
//  pop_mf         out  1      pop MF into VC[mf_head_vc]
//  pop_vc0        out  1      pop VC0 into demux;  pop_vc1 out 1  pop VC1 into demux
//  demux_sel      out  1      0=VC0 1=VC1 drives VC->D mux (valid with pop_vc*)
//  Pausa_MF       out  1      MF almost full, upstream must stop pushing
//  init_out, idle_out, active_out, error_out  out 1 each  one-hot state flags
// BEHAVIOUR
//  Reset (reset=1 at posedge): state=RESET, thresholds=*_RST, starve_cnt=0, all outputs 0. Mid-operation reset aborts at once; pops drop to 0 same cycle.
//  FSM (registered): RESET->INIT next cycle. INIT: load all umbral_* every cycle; ->IDLE when init=0.
//   IDLE: ->ACTIVE when any count!=0. ACTIVE: ->IDLE when all five counts==0 and no pop asserted.
//   From IDLE/ACTIVE: fifo_err!=0 -> ERROR (priority over init and idle/active moves). ERROR sticky; exits only via init=1 -> INIT, or reset.
//   init=1 in IDLE/ACTIVE -> INIT. Flags registered, exactly one high except in RESET (all 0).
//  Almost-full: af_X = (umbral_X != 0) && (count_X >= umbral_X); threshold 0 disables. Zero-extend for compare.
//  Pausa_MF: registered af_mf, 1-cycle latency; forced 0 in RESET, 1 in ERROR and INIT.
//  Pops combinational from current state/inputs, only in ACTIVE (0 elsewhere):
//   pop_mf  = mf_count!=0 && !af_vc[mf_head_vc].
//   elig0 = vc0_count!=0 && !af_d[vc0_head_dest]; elig1 likewise for VC1.
//   One demux grant per cycle: VC0 wins unless starve_cnt==STARVE_MAX && elig1. demux_sel=1 only when pop_vc1.
//  starve_cnt: +1 on VC0 grant while elig1; cleared on VC1 grant, or elig1=0; saturates at STARVE_MAX; cleared outside ACTIVE.
//  Never pop an empty FIFO; never pop into a D/VC whose af is set the same cycle.
// STRUCTURE
//  pcie_trans_defs.vh: state encodings (RESET=0,INIT=1,IDLE=2,ACTIVE=3,ERROR=4), threshold widths, fifo_err bit indices.
//  Sub-module vc_arbiter: elig0/elig1 + starve counter -> pop_vc0/pop_vc1/demux_sel. Thresholds, FSM, Pausa_MF stay in top.
// TESTING
//  1 reset 2 cycles, init=1 with umbral_mf=3,vc0=4,d0=2, init=0 -> INIT then IDLE flags, thresholds held after init drops.
//  2 ACTIVE, mf_count=3, umbral_mf=3 -> Pausa_MF=1 one cycle later; mf_count=2 -> Pausa_MF=0 one cycle later.
//  3 vc0/vc1 non-empty, both dest D0, d0_count=1 (<2) -> pop_vc0 only; d0_count=2 -> both pops 0 and MF still pops if VC not af.
//  4 STARVE_MAX=4, both eligible continuously -> grant pattern VC0 x4, VC1 x1, repeat; demux_sel tracks.
//  5 fifo_err=5'b00100 in ACTIVE -> error_out next cycle, pops 0, Pausa_MF=1; clear err -> stays ERROR; init=1 -> INIT.
//  6 reset=1 mid-burst with pops active -> pops 0 same cycle, all flags 0 next edge, thresholds at *_RST.

Source files
------------

// File: rtl/pcie_flow_ctrl_pkg.sv
// Shared definitions for the PCIe transaction flow controller: link states,
// occupancy/threshold widths and the almost-full compare.
package pcie_flow_ctrl_pkg;

  localparam int MF_CW = 3;
  localparam int VC_CW = 5;
  localparam int D_CW  = 3;
  localparam int UMF_W = 2;
  localparam int UVC_W = 4;
  localparam int UD_W  = 2;
  localparam int ERR_W = 5;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } fc_state_e;

  // A zero threshold disables the flag; operands arrive zero-extended.
  function automatic logic almost_full(input logic [7:0] count, input logic [7:0] thr);
    return (thr != 8'd0) && (count >= thr);
  endfunction

endpackage

// File: rtl/pcie_flow_ctrl_if.sv
// Control bundle between the flow controller (master) and the external
// FIFO/mux datapath (slave).
interface pcie_flow_ctrl_if;
  import pcie_flow_ctrl_pkg::*;

  logic             init;
  logic [UMF_W-1:0] umbral_mf;
  logic [UVC_W-1:0] umbral_vc0;
  logic [UVC_W-1:0] umbral_vc1;
  logic [UD_W-1:0]  umbral_d0;
  logic [UD_W-1:0]  umbral_d1;
  logic [MF_CW-1:0] mf_count;
  logic [VC_CW-1:0] vc0_count;
  logic [VC_CW-1:0] vc1_count;
  logic [D_CW-1:0]  d0_count;
  logic [D_CW-1:0]  d1_count;
  logic             mf_head_vc;
  logic             vc0_head_dest;
  logic             vc1_head_dest;
  logic [ERR_W-1:0] fifo_err;   // {d1,d0,vc1,vc0,mf}
  logic             pop_mf;
  logic             pop_vc0;
  logic             pop_vc1;
  logic             demux_sel;
  logic             Pausa_MF;
  logic             init_out;
  logic             idle_out;
  logic             active_out;
  logic             error_out;

  modport master (
    input  init, umbral_mf, umbral_vc0, umbral_vc1, umbral_d0, umbral_d1,
           mf_count, vc0_count, vc1_count, d0_count, d1_count,
           mf_head_vc, vc0_head_dest, vc1_head_dest, fifo_err,
    output pop_mf, pop_vc0, pop_vc1, demux_sel, Pausa_MF,
           init_out, idle_out, active_out, error_out
  );

  modport slave (
    output init, umbral_mf, umbral_vc0, umbral_vc1, umbral_d0, umbral_d1,
           mf_count, vc0_count, vc1_count, d0_count, d1_count,
           mf_head_vc, vc0_head_dest, vc1_head_dest, fifo_err,
    input  pop_mf, pop_vc0, pop_vc1, demux_sel, Pausa_MF,
           init_out, idle_out, active_out, error_out
  );

endinterface

// File: rtl/pcie_flow_ctrl_vc_arbiter.sv
// VC0/VC1 -> D demux arbiter: VC0 has priority, but after STARVE_MAX
// consecutive VC0 grants with VC1 waiting, VC1 gets one grant.
module pcie_flow_ctrl_vc_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic elig0,
  input  logic elig1,
  output logic pop_vc0,
  output logic pop_vc1,
  output logic demux_sel
);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       grant0, grant1;

  always_comb begin
    grant1       = en && elig1 && (!elig0 || (starve_cnt_q == 4'(STARVE_MAX)));
    grant0       = en && elig0 && !grant1;
    pop_vc0      = grant0;
    pop_vc1      = grant1;
    demux_sel    = grant1;
    starve_cnt_d = starve_cnt_q;
    if (!en || grant1 || !elig1) begin
      starve_cnt_d = 4'd0;
    end else if (grant0 && (starve_cnt_q != 4'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/pcie_flow_ctrl.sv
// Link FSM, threshold latch, MF/VC pop strobes and Pausa_MF for the PCIe
// transaction datapath; the FIFOs and muxes themselves live outside.
module pcie_flow_ctrl
  import pcie_flow_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int UMF_RST    = 3,
  parameter int UVC_RST    = 12,
  parameter int UD_RST     = 3
) (
  input  logic              clk,
  input  logic              reset,
  pcie_flow_ctrl_if.master  bus
);

  fc_state_e        state_q, state_d;
  logic [UMF_W-1:0] umf_q, umf_d;
  logic [UVC_W-1:0] uvc0_q, uvc0_d, uvc1_q, uvc1_d;
  logic [UD_W-1:0]  ud0_q, ud0_d, ud1_q, ud1_d;
  logic             pausa_q, pausa_d;
  logic             af_mf, af_vc0, af_vc1, af_d0, af_d1;
  logic             is_active, pop_mf, elig0, elig1, any_cnt;
  logic             pop_vc0, pop_vc1, demux_sel;

  always_comb begin
    af_mf  = almost_full(8'(bus.mf_count),  8'(umf_q));
    af_vc0 = almost_full(8'(bus.vc0_count), 8'(uvc0_q));
    af_vc1 = almost_full(8'(bus.vc1_count), 8'(uvc1_q));
    af_d0  = almost_full(8'(bus.d0_count),  8'(ud0_q));
    af_d1  = almost_full(8'(bus.d1_count),  8'(ud1_q));
    // Gated by reset so an in-flight burst stops in the same cycle.
    is_active = (state_q == ST_ACTIVE) && !reset;
    pop_mf    = is_active && (bus.mf_count != '0) &&
                !(bus.mf_head_vc ? af_vc1 : af_vc0);
    elig0     = (bus.vc0_count != '0) && !(bus.vc0_head_dest ? af_d1 : af_d0);
    elig1     = (bus.vc1_count != '0) && !(bus.vc1_head_dest ? af_d1 : af_d0);
    any_cnt   = (bus.mf_count != '0) || (bus.vc0_count != '0) ||
                (bus.vc1_count != '0) || (bus.d0_count != '0) ||
                (bus.d1_count != '0);
  end

  pcie_flow_ctrl_vc_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_vc_arbiter (
    .clk       (clk),
    .reset     (reset),
    .en        (is_active),
    .elig0     (elig0),
    .elig1     (elig1),
    .pop_vc0   (pop_vc0),
    .pop_vc1   (pop_vc1),
    .demux_sel (demux_sel)
  );

  always_comb begin
    state_d = state_q;
    umf_d   = umf_q;
    uvc0_d  = uvc0_q;
    uvc1_d  = uvc1_q;
    ud0_d   = ud0_q;
    ud1_d   = ud1_q;
    pausa_d = af_mf;
    if (state_q == ST_INIT) begin
      umf_d  = bus.umbral_mf;
      uvc0_d = bus.umbral_vc0;
      uvc1_d = bus.umbral_vc1;
      ud0_d  = bus.umbral_d0;
      ud1_d  = bus.umbral_d1;
    end
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  if (!bus.init) state_d = ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        // A FIFO fault outranks both re-init and idle/active moves.
        if (bus.fifo_err != '0) begin
          state_d = ST_ERROR;
        end else if (bus.init) begin
          state_d = ST_INIT;
        end else if ((state_q == ST_IDLE) && any_cnt) begin
          state_d = ST_ACTIVE;
        end else if ((state_q == ST_ACTIVE) && !any_cnt &&
                     !(pop_mf || pop_vc0 || pop_vc1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: if (bus.init) state_d = ST_INIT;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      umf_q   <= UMF_W'(UMF_RST);
      uvc0_q  <= UVC_W'(UVC_RST);
      uvc1_q  <= UVC_W'(UVC_RST);
      ud0_q   <= UD_W'(UD_RST);
      ud1_q   <= UD_W'(UD_RST);
      pausa_q <= 1'b0;
    end else begin
      state_q <= state_d;
      umf_q   <= umf_d;
      uvc0_q  <= uvc0_d;
      uvc1_q  <= uvc1_d;
      ud0_q   <= ud0_d;
      ud1_q   <= ud1_d;
      pausa_q <= pausa_d;
    end
  end

  assign bus.pop_mf     = pop_mf;
  assign bus.pop_vc0    = pop_vc0;
  assign bus.pop_vc1    = pop_vc1;
  assign bus.demux_sel  = demux_sel;
  assign bus.Pausa_MF   = ((state_q == ST_INIT) || (state_q == ST_ERROR)) ? 1'b1 :
                          ((state_q == ST_RESET) ? 1'b0 : pausa_q);
  assign bus.init_out   = (state_q == ST_INIT);
  assign bus.idle_out   = (state_q == ST_IDLE);
  assign bus.active_out = (state_q == ST_ACTIVE);
  assign bus.error_out  = (state_q == ST_ERROR);

endmodule
